slow_path_ctrl: RTL

- Shares one slow, purely combinational unit among NUM_REQ requesters. The unit is the 8-bit inverter delay chain or the slow ROM lookup in the microprocessor lab.
- Arbitrates the requests and drives the chosen operand onto the slow unit's input.
- Holds that operand stable for a programmable number of wait cycles, then registers the unit's output.
- Returns the result to the winning requester over a valid/ready handshake.

---
 rtl/slow_path_ctrl_pkg.sv | 22 ++
 rtl/slow_path_arbiter.sv | 55 +++++
 rtl/slow_path_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/slow_path_ctrl_pkg.sv
// slow_path_ctrl_pkg: shared types and helpers for the slow-path controller.
// Optional feature macro used by this codebase slice: SLOW_PATH_CTRL_RR_ARB_EN
// (round-robin arbitration instead of fixed lowest-index priority).
package slow_path_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A wait setting of 0 would give the slow unit no settle time at all,
    // so the smallest effective wait is one full cycle.
    localparam int unsigned MIN_WAIT = 1;

    // Effective wait count: max(x, MIN_WAIT)
    function automatic logic [31:0] eff_wait(input logic [31:0] x);
        return (x < MIN_WAIT) ? MIN_WAIT : x;
    endfunction

endpackage

// File: rtl/slow_path_arbiter.sv
// slow_path_arbiter: combinational request selector for slow_path_ctrl.
// Default build: fixed priority, lowest index wins (pointer input unused).
// With SLOW_PATH_CTRL_RR_ARB_EN defined: round-robin search starting at the
// pointer and wrapping modulo NUM_REQ.
module slow_path_arbiter
    import slow_path_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

`ifdef SLOW_PATH_CTRL_RR_ARB_EN
    // Round-robin: first active request at or after the pointer, wrapping
    always_comb begin
        int k;
        k     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(i_ptr) + i) % NUM_REQ;
            if (!o_any && i_req[k]) begin
                o_any    = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = ID_W'(k);
            end
        end
    end
`else
    // The pointer only matters for round-robin; keep it consumed here.
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    // Fixed priority: the lowest-numbered active request wins
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[i]) begin
                o_any    = 1'b1;
                o_gnt[i] = 1'b1;
                o_idx    = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/slow_path_ctrl.sv
// slow_path_ctrl: shares one slow combinational unit among NUM_REQ requesters.
// A winner's operand is driven to the unit, held for max(wait,1) cycles, the
// unit's output is registered and returned over a valid/ready handshake.
// Optional feature macro: SLOW_PATH_CTRL_RR_ARB_EN (round-robin arbitration
// with a registered pointer; undefined gives fixed priority and no pointer).
module slow_path_ctrl
    import slow_path_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_in,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
    output logic [NUM_REQ-1:0]        gnt_out,
    input  logic [CNT_W-1:0]          wait_cycles_in,
    output logic [DATA_W-1:0]         slow_data_out,
    input  logic [DATA_W-1:0]         slow_data_in,
    output logic                      resp_valid_out,
    input  logic                      resp_ready_in,
    output logic [DATA_W-1:0]         resp_data_out,
    output logic [ID_W-1:0]           resp_id_out,
    output logic                      busy_out
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [DATA_W-1:0]   r_slow_data;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [ID_W-1:0]     r_id;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic [ID_W-1:0]     w_ptr;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_grant_now;

    // A grant can only happen from IDLE; requests elsewhere are ignored.
    assign w_grant_now = (r_state == IDLE) && w_any;

    slow_path_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req (req_in),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

`ifdef SLOW_PATH_CTRL_RR_ARB_EN
    logic [ID_W-1:0] r_ptr;

    // Round-robin pointer: move just past the requester that was granted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_grant_now) begin
            r_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : (w_idx + ID_W'(1));
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Operand mux: pick the winning requester's slice of the flattened bus
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = req_data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Controller FSM with the wait counter and operand/result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_slow_data <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_id        <= '0;
        end else begin
            // Grant is a single-cycle pulse
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt       <= w_gnt;
                        r_slow_data <= w_sel_data;
                        r_id        <= w_idx;
                        r_cnt       <= CNT_W'(eff_wait(32'(wait_cycles_in)));
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    // Operand has been stable for the full wait when cnt hits 1
                    if (r_cnt == CNT_W'(MIN_WAIT)) begin
                        r_data  <= slow_data_in;
                        r_valid <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready_in) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_out        = r_gnt;
    assign slow_data_out  = r_slow_data;
    assign resp_valid_out = r_valid;
    assign resp_data_out  = r_data;
    assign resp_id_out    = r_id;
    assign busy_out       = (r_state != IDLE);

endmodule
